// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: valid/ready TX and RX, mid-bit RX sampling with
// start-glitch rejection, and a receive FIFO carrying per-character error flags.
module uart_param_core #(
    parameter int CLKS_PER_BIT  = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 tx_o,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_done_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 rx_parity_err_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_overrun_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam int WW = DATA_BITS + 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DBIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SBIT_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    // ---------------- transmitter ----------------
    state_t                 tx_state, tx_state_nxt;
    logic [CW-1:0]          tx_cnt;
    logic [3:0]             tx_bit;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_par;
    logic                   tx_tick, tx_last, tx_line;

    assign tx_tick    = (tx_cnt == CNT_LAST);
    assign tx_ready_o = (tx_state == S_IDLE);
    assign tx_o       = tx_line;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_line      = 1'b1;
        tx_last      = 1'b0;
        case (tx_state)
            S_IDLE:   if (tx_valid_i) tx_state_nxt = S_START;
            S_START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_state_nxt = S_DATA;
            end
            S_DATA: begin
                tx_line = tx_shift[0];
                if (tx_tick && tx_bit == DBIT_LAST)
                    tx_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_line = tx_par;
                if (tx_tick) tx_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (tx_tick && tx_bit == SBIT_LAST) begin
                    tx_state_nxt = S_IDLE;
                    tx_last      = 1'b1;
                end
            end
            default: tx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_done_o <= 1'b0;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_done_o <= tx_last;
            if (tx_state == S_IDLE || tx_state != tx_state_nxt) begin
                tx_cnt <= '0;
                tx_bit <= '0;
            end else if (tx_tick) begin
                tx_cnt <= '0;
                tx_bit <= tx_bit + 4'd1;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_state == S_IDLE && tx_valid_i) begin
            tx_shift <= tx_data_i;
            tx_par   <= parity_bit(tx_data_i);
        end else if (tx_state == S_DATA && tx_tick) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    // ---------------- receiver: synchronizer stages p0/p1 ----------------
    logic rx_sync_p0, rx_sync_p1, rx_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_i;
            rx_sync_p1 <= rx_sync_p0;
        end
    end
    assign rx_s = rx_sync_p1;

    state_t                 rx_state, rx_state_nxt;
    logic [CW-1:0]          rx_cnt;
    logic [3:0]             rx_bit;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_perr, rx_ferr, rx_armed;
    logic                   rx_tick, push;
    logic [WW-1:0]          push_word;

    assign rx_tick   = (rx_state == S_START) ? (rx_cnt == CNT_MID) : (rx_cnt == CNT_LAST);
    assign push_word = {rx_ferr | ~rx_s, rx_perr, rx_shift};

    always_comb begin
        rx_state_nxt = rx_state;
        push         = 1'b0;
        case (rx_state)
            S_IDLE:   if (rx_armed && !rx_s) rx_state_nxt = S_START;
            S_START:  if (rx_tick) rx_state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (rx_tick && rx_bit == DBIT_LAST)
                    rx_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (rx_tick) rx_state_nxt = S_STOP;
            S_STOP: begin
                if (rx_tick && rx_bit == SBIT_LAST) begin
                    rx_state_nxt = S_IDLE;
                    push         = 1'b1;
                end
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    // armed tracks the last line level seen while returning to or waiting in IDLE,
    // so a start needs a 1->0 transition and a frame error waits for the line to recover
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_armed <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_state_nxt == S_IDLE) rx_armed <= rx_s;
            if (rx_state == S_IDLE || rx_state != rx_state_nxt) begin
                rx_cnt <= '0;
                rx_bit <= '0;
            end else if (rx_tick) begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 4'd1;
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_state == S_IDLE) begin
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
        end
        if (rx_state == S_DATA && rx_tick)
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
        if (rx_state == S_PARITY && rx_tick)
            rx_perr <= (rx_s != parity_bit(rx_shift));
        if (rx_state == S_STOP && rx_tick && !rx_s)
            rx_ferr <= 1'b1;
    end

    // ---------------- receive FIFO ----------------
    logic [WW-1:0] mem [RX_FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic          full, pop, push_ok, drop;
    logic [WW-1:0] head_nxt;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = rx_valid_o && rx_ready_i;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign wr_nxt  = wr_ptr + {{AW{1'b0}}, push_ok};
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, pop};

    // the entry being written this cycle is not in mem yet, so bypass it to the head
    always_comb begin
        head_nxt = '0;
        if (wr_nxt != rd_nxt) begin
            if (push_ok && rd_nxt[AW-1:0] == wr_ptr[AW-1:0])
                head_nxt = push_word;
            else
                head_nxt = mem[rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            rx_valid_o      <= 1'b0;
            rx_data_o       <= '0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_overrun_o    <= 1'b0;
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            rx_valid_o <= (wr_nxt != rd_nxt);
            {rx_frame_err_o, rx_parity_err_o, rx_data_o} <= head_nxt;
            if (drop)
                rx_overrun_o <= 1'b1;
            else if (pop)
                rx_overrun_o <= 1'b0;
        end
    end

endmodule
